memref_port_arbiter: RTL

//   Shares one single-port memref (1-cycle read latency, as driven by memref_rd/memref_wr)

---
 rtl/memref_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/memref_port_arbiter.sv
// Round-robin arbiter sharing one single-port memref (1-cycle read latency) among NUM_REQ
// requesters; registered command, in-order tagged responses. Optional grant lock: MEMREF_ARB_LOCK_EN.
module memref_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [WIDTH-1:0]          mem_wr_data,
  input  logic [WIDTH-1:0]          mem_rd_data
);
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, LOCKED} state_t;

  state_t                              state;
  logic [IDW-1:0]                      rr_ptr;
  logic [IDW-1:0]                      gnt_id;
  logic                                gnt_any;
  logic                                rd_acc;
  logic [NUM_REQ-1:0][ADDR_W-1:0]      addr_a;
  logic [NUM_REQ-1:0][WIDTH-1:0]       wdata_a;
  logic [STAGES-1:0]                   vld_pipe;
  logic [STAGES-1:0][IDW-1:0]          id_pipe;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_a[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef MEMREF_ARB_LOCK_EN
  logic [IDW-1:0] owner;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
`ifdef MEMREF_ARB_LOCK_EN
    if (state == LOCKED) begin
      gnt_any = req_valid[owner];
      gnt_id  = owner;
    end else
`endif
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
    if (!rst) gnt_any = 1'b0;
    req_ready[gnt_id] = gnt_any;
  end

  assign rd_acc = gnt_any & ~req_wr[gnt_id];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
`ifdef MEMREF_ARB_LOCK_EN
      owner       <= '0;
`endif
    end else begin
      mem_rd_en <= rd_acc;
      mem_wr_en <= gnt_any & req_wr[gnt_id];
      vld_pipe  <= {vld_pipe[STAGES-2:0], rd_acc};
      id_pipe   <= {id_pipe[STAGES-2:0], gnt_id};
      if (gnt_any) begin
        mem_addr    <= addr_a[gnt_id];
        mem_wr_data <= wdata_a[gnt_id];
        // While locked only the owner is granted, so this value is constant until release.
        rr_ptr      <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef MEMREF_ARB_LOCK_EN
        if (req_lock[gnt_id]) begin
          state <= LOCKED;
          owner <= gnt_id;
        end else begin
          state <= ACTIVE;
        end
`else
        state <= ACTIVE;
`endif
      end else if (state != LOCKED) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_valid[id_pipe[STAGES-1]] = vld_pipe[STAGES-1];
  end

  assign rsp_data = mem_rd_data;

endmodule
